// File: rtl/uart_tx_arb_pkg.sv
// ============================================================================
// Module   : uart_tx_arb_pkg
// Purpose  : Shared FSM state type and sizing helpers for the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    function automatic int idle_th(input int idle_bits, input int baud_period);
        return idle_bits * baud_period;
    endfunction

    // Width able to hold every value 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_line_idle_detector.sv
// ============================================================================
// Module   : uart_line_idle_detector
// Purpose  : Flags a serial line idle once it has been high IDLE_TH cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_line_idle_detector
    import uart_tx_arb_pkg::*;
#(
    parameter int IDLE_TH = 1144
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic idle
);

    localparam int                 c_CNT_W = cnt_width(IDLE_TH);
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(IDLE_TH);

    logic [c_CNT_W-1:0] r_cnt;

    // Saturating run-length of the high level; any low bit restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!line) begin
            r_cnt <= '0;
        end else if (r_cnt != c_TERM) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign idle = (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Frame-safe two-source UART TX pin arbiter with idle guard gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int BAUD_PERIOD = 104,
    parameter int IDLE_BITS   = 11
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tx_cpu,
    input  logic tx_ocd,
    input  logic sel_ocd1_cpu0,
    output logic TXD,
    output logic active_src,
    output logic switch_pending
);

    localparam int                 c_IDLE_TH  = idle_th(IDLE_BITS, BAUD_PERIOD);
    localparam int                 c_GAP_W    = cnt_width(BAUD_PERIOD);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(BAUD_PERIOD - 1);

    logic               r_tx_cpu;
    logic               r_tx_ocd;
    logic               r_sel;
    logic               r_txd;
    logic               r_active;
    logic               r_target;
    arb_state_t         r_state;
    logic [c_GAP_W-1:0] r_gap_cnt;

    logic               w_idle_cpu;
    logic               w_idle_ocd;
    logic               w_src_bit;
    arb_state_t         w_state_nxt;
    logic               w_enter_gap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_cpu <= 1'b1;
            r_tx_ocd <= 1'b1;
            r_sel    <= 1'b0;
        end else begin
            r_tx_cpu <= tx_cpu;
            r_tx_ocd <= tx_ocd;
            r_sel    <= sel_ocd1_cpu0;
        end
    end

    uart_line_idle_detector #(
        .IDLE_TH (c_IDLE_TH)
    ) u_idle_cpu (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (r_tx_cpu),
        .idle    (w_idle_cpu)
    );

    uart_line_idle_detector #(
        .IDLE_TH (c_IDLE_TH)
    ) u_idle_ocd (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (r_tx_ocd),
        .idle    (w_idle_ocd)
    );

    assign w_src_bit = r_active ? r_tx_ocd : r_tx_cpu;

    always_comb begin
        w_state_nxt = r_state;
        w_enter_gap = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_sel != r_active) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A request withdrawn in the same cycle both lines qualify wins.
                if (r_sel == r_active) begin
                    w_state_nxt = ST_RUN;
                end else if (w_idle_cpu && w_idle_ocd) begin
                    w_state_nxt = ST_GAP;
                    w_enter_gap = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_RUN;
            r_active  <= 1'b0;
            r_target  <= 1'b0;
            r_gap_cnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN && w_state_nxt == ST_WAIT) begin
                r_target <= r_sel;
            end
            if (w_enter_gap) begin
                r_active  <= r_target;
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP && r_gap_cnt != c_GAP_LAST) begin
                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            end
            r_txd <= (r_state == ST_GAP) ? 1'b1 : w_src_bit;
        end
    end

    assign TXD            = r_txd;
    assign active_src     = r_active;
    assign switch_pending = (r_state != ST_RUN) || (r_sel != r_active);

endmodule

`default_nettype wire
